// File: rtl/dm_cache_responder.sv
// Direct-mapped, write-back, write-allocate single-word-per-line cache responder.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module dm_cache_responder #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 15 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WB, FILL, CMPL} state_t;

  state_t                state;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [15:0]           data_mem [LINES];
  logic [LINES-1:0]      valid_bits;
  logic [LINES-1:0]      dirty_bits;
  logic                  req_wr;
  logic                  dropped;
  logic                  cmpl_ok;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  req;
  logic                  accept;
  logic                  hit;
  logic                  idle_hit;
  logic                  idle_miss;
  logic                  victim_dirty;
  logic                  unused_ok;

  assign unused_ok    = createdump;
  assign idx          = Addr[INDEX_BITS:1];
  assign tag          = Addr[15:INDEX_BITS+1];
  assign req          = Rd | Wr;
  assign err          = (req & Addr[0]) | (Rd & Wr);
  assign accept       = req & ~err;
  assign hit          = valid_bits[idx] && (tag_mem[idx] == tag);
  assign victim_dirty = valid_bits[idx] & dirty_bits[idx];
  assign idle_hit     = (state == IDLE) && accept && hit;
  assign idle_miss    = (state == IDLE) && accept && !hit;

  // Hits answer in the same cycle, so the requester-facing outputs are decoded from state and inputs
  assign Done     = idle_hit | ((state == CMPL) & cmpl_ok);
  assign CacheHit = idle_hit;
  assign Stall    = idle_miss | (state == WB) | (state == FILL);
  assign DataOut  = ((idle_hit & Rd) | ((state == CMPL) & cmpl_ok & ~req_wr)) ? data_mem[idx] : 16'h0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      valid_bits <= '0;
      dirty_bits <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_wdata  <= 16'h0000;
      req_wr     <= 1'b0;
      dropped    <= 1'b0;
      cmpl_ok    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_hit && Wr) begin
            dirty_bits[idx] <= 1'b1;
          end
          if (idle_miss) begin
            req_wr  <= Wr;
            dropped <= 1'b0;
            if (victim_dirty) begin
              state     <= WB;
              mem_wr    <= 1'b1;
              mem_addr  <= {tag_mem[idx], idx, 1'b0};
              mem_wdata <= data_mem[idx];
            end else begin
              state    <= FILL;
              mem_rd   <= 1'b1;
              mem_addr <= {Addr[15:1], 1'b0};
            end
          end
        end
        WB: begin
          if (!req) begin
            dropped <= 1'b1;
          end
          if (mem_ready) begin
            dirty_bits[idx] <= 1'b0;
            mem_wr          <= 1'b0;
            mem_rd          <= 1'b1;
            mem_addr        <= {Addr[15:1], 1'b0};
            mem_wdata       <= 16'h0000;
            state           <= FILL;
          end
        end
        FILL: begin
          if (!req) begin
            dropped <= 1'b1;
          end
          if (mem_ready) begin
            valid_bits[idx] <= 1'b1;
            dirty_bits[idx] <= 1'b0;
            mem_rd          <= 1'b0;
            mem_addr        <= 16'h0000;
            cmpl_ok         <= req & ~dropped;
            state           <= CMPL;
          end
        end
        CMPL: begin
          if (cmpl_ok && req_wr) begin
            dirty_bits[idx] <= 1'b1;
          end
          cmpl_ok <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; the valid bits qualify them
  always_ff @(posedge clk) begin
    if (idle_hit && Wr) begin
      data_mem[idx] <= DataIn;
    end else if ((state == FILL) && mem_ready) begin
      data_mem[idx] <= mem_rdata;
      tag_mem[idx]  <= tag;
    end else if ((state == CMPL) && cmpl_ok && req_wr) begin
      data_mem[idx] <= DataIn;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else begin
      if (idle_hit && (hit_count != 16'hFFFF)) begin
        hit_count <= hit_count + 16'h0001;
      end
      if (idle_miss && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_cache_responder.sv
// Bench for dm_cache_responder: a flat-memory golden model plus a delayed backing-memory responder.
// Connects and checks the statistics ports when CACHE_STATS_EN is defined.
module tb_dm_cache_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn;
  logic        Rd, Wr, createdump;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, err;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  dm_cache_responder #(.INDEX_BITS(4)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall),
    .CacheHit(CacheHit), .err(err), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {bit wr; logic [15:0] addr; logic [15:0] data;} mem_ev_t;

  int checks = 0;
  int errors = 0;

  // Architectural memory contents and what the backing store actually holds
  logic [15:0] golden  [logic [15:0]];
  logic [15:0] backing [logic [15:0]];
  mem_ev_t     mem_log [$];
  int          wb_delay = 1, fill_delay = 1, mem_cnt = 0;
  bit          both_seen = 0;

  // Which lines the cache should be holding, in terms of whole addresses
  bit          mvalid [16];
  bit          mdirty [16];
  logic [10:0] mtag   [16];
  int          exp_hits = 0, exp_misses = 0;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] backing_val(input logic [15:0] a);
    return backing.exists(a) ? backing[a] : init_val(a);
  endfunction

  function automatic logic [15:0] golden_val(input logic [15:0] a);
    return golden.exists(a) ? golden[a] : backing_val(a);
  endfunction

  // Backing memory: answers each strobe after a configurable number of cycles
  always @(negedge clk) begin
    if (rst) begin
      mem_ready = 1'b0;
      mem_cnt   = 0;
    end else begin
      mem_ready = 1'b0;
      if (mem_rd && mem_wr) both_seen = 1;
      if (mem_rd || mem_wr) begin
        mem_cnt++;
        if (mem_cnt >= (mem_wr ? wb_delay : fill_delay)) begin
          mem_log.push_back('{mem_wr, mem_addr, mem_wdata});
          if (mem_wr) backing[mem_addr] = mem_wdata;
          else        mem_rdata = backing_val(mem_addr);
          mem_ready = 1'b1;
          mem_cnt   = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mvalid[i] = 0;
      mdirty[i] = 0;
    end
    golden     = backing;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // One complete request, entered and left 1 time unit after a rising edge
  task automatic applyStimulus(input bit is_wr, input logic [15:0] a, input logic [15:0] d,
                               input int dw, input int df);
    logic [3:0]  i;
    logic [10:0] t;
    logic [15:0] exp_rd, exp_victim;
    bit          exp_hit, exp_wb, done_ok;
    int          stall_cnt, n_ev;
    logic [15:0] obs_data;
    logic        obs_hit;
    i          = a[4:1];
    t          = a[15:5];
    exp_hit    = mvalid[i] && (mtag[i] == t);
    exp_wb     = !exp_hit && mvalid[i] && mdirty[i];
    exp_victim = {mtag[i], i, 1'b0};
    exp_rd     = golden_val(a);
    wb_delay   = dw;
    fill_delay = df;
    mem_log.delete();
    Rd = !is_wr; Wr = is_wr; Addr = a; DataIn = d;
    done_ok = 0; stall_cnt = 0; obs_data = 16'h0; obs_hit = 1'b0;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (Done === 1'b1) begin
        done_ok  = 1;
        obs_data = DataOut;
        obs_hit  = CacheHit;
        break;
      end
      if (Stall === 1'b1) stall_cnt++;
      @(posedge clk); #1;
    end
    checkOutput("done_seen", 16'(done_ok), 16'd1);
    checkOutput("err_clear", 16'(err), 16'd0);
    checkOutput("cache_hit", 16'(obs_hit), 16'(exp_hit));
    checkOutput("stall_cycles", 16'(stall_cnt), exp_hit ? 16'd0 : 16'(1 + (exp_wb ? dw : 0) + df));
    if (!is_wr) checkOutput("read_data", obs_data, exp_rd);
    n_ev = exp_hit ? 0 : (exp_wb ? 2 : 1);
    checkOutput("mem_events", 16'(mem_log.size()), 16'(n_ev));
    if (mem_log.size() == n_ev && n_ev == 2) begin
      checkOutput("wb_is_write", 16'(mem_log[0].wr), 16'd1);
      checkOutput("wb_addr", mem_log[0].addr, exp_victim);
      checkOutput("wb_data", mem_log[0].data, golden_val(exp_victim));
    end
    if (mem_log.size() == n_ev && n_ev > 0) begin
      checkOutput("fill_is_read", 16'(mem_log[n_ev-1].wr), 16'd0);
      checkOutput("fill_addr", mem_log[n_ev-1].addr, {a[15:1], 1'b0});
    end
    if (exp_hit) begin
      exp_hits++;
      if (is_wr) mdirty[i] = 1;
    end else begin
      exp_misses++;
      mvalid[i] = 1;
      mtag[i]   = t;
      mdirty[i] = is_wr;
    end
    if (is_wr) golden[a] = d;
    @(posedge clk); #1;
    Rd = 0; Wr = 0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int done_cnt;
    rst = 1; Rd = 0; Wr = 0; Addr = 0; DataIn = 0; createdump = 0;
    mem_rdata = 0; mem_ready = 0;
    model_reset();
    #2;
    checkOutput("rst_DataOut", DataOut, 16'h0);
    checkOutput("rst_Done", 16'(Done), 16'd0);
    checkOutput("rst_Stall", 16'(Stall), 16'd0);
    checkOutput("rst_CacheHit", 16'(CacheHit), 16'd0);
    checkOutput("rst_err", 16'(err), 16'd0);
    checkOutput("rst_mem_rd", 16'(mem_rd), 16'd0);
    checkOutput("rst_mem_wr", 16'(mem_wr), 16'd0);
    checkOutput("rst_mem_addr", mem_addr, 16'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 16'h0);
    @(posedge clk); #1;
    rst = 0;

    // Cold read, repeat hit, write hit, dirty eviction
    backing[16'h0010] = 16'hBEEF;
    golden[16'h0010]  = 16'hBEEF;
    applyStimulus(0, 16'h0010, 16'h0000, 1, 3);
    applyStimulus(0, 16'h0010, 16'h0000, 1, 1);
    applyStimulus(1, 16'h0010, 16'h1234, 1, 1);
    applyStimulus(0, 16'h0030, 16'h0000, 2, 2);
    checkOutput("wb_landed", backing_val(16'h0010), 16'h1234);

    // Write miss onto a clean victim, then read it back as a hit
    applyStimulus(1, 16'h0042, 16'hA5A5, 1, 1);
    applyStimulus(0, 16'h0042, 16'h0000, 1, 1);

    // Requester drops Rd mid-fill: the fill completes but no Done is raised
    mem_log.delete();
    fill_delay = 3; wb_delay = 1;
    Rd = 1; Addr = 16'h0060;
    #1;
    checkOutput("drop_stall", 16'(Stall), 16'd1);
    @(posedge clk); #1;
    Rd = 0;
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (Done === 1'b1) done_cnt++;
      @(posedge clk); #1;
    end
    checkOutput("drop_no_done", 16'(done_cnt), 16'd0);
    checkOutput("drop_mem_events", 16'(mem_log.size()), 16'd1);
    exp_misses++;
    mvalid[0] = 1; mtag[0] = 11'd3; mdirty[0] = 0;
    applyStimulus(0, 16'h0060, 16'h0000, 1, 1);

    // Illegal requests
    mem_log.delete();
    Rd = 1; Addr = 16'h0011;
    #1;
    checkOutput("err_odd", 16'(err), 16'd1);
    checkOutput("err_odd_done", 16'(Done), 16'd0);
    checkOutput("err_odd_stall", 16'(Stall), 16'd0);
    @(posedge clk); #1;
    checkOutput("err_no_strobe", 16'(mem_rd | mem_wr), 16'd0);
    Wr = 1; Addr = 16'h0010;
    #1;
    checkOutput("err_rdwr", 16'(err), 16'd1);
    checkOutput("err_rdwr_done", 16'(Done), 16'd0);
    @(posedge clk); #1;
    Rd = 0; Wr = 0;
    checkOutput("err_mem_events", 16'(mem_log.size()), 16'd0);

    // Randomised traffic over four tags per line to force hits and evictions
    for (int n = 0; n < 80; n++) begin
      logic [10:0] t;
      logic [3:0]  i;
      t = 11'($urandom_range(0, 3));
      i = 4'($urandom_range(0, 15));
      applyStimulus(1'($urandom_range(0, 1)), {t, i, 1'b0}, 16'($urandom),
                    $urandom_range(1, 4), $urandom_range(1, 4));
    end

`ifdef CACHE_STATS_EN
    checkOutput("hit_count", hit_count, 16'(exp_hits));
    checkOutput("miss_count", miss_count, 16'(exp_misses));
`endif

    // Asynchronous reset in the middle of a fill
    fill_delay = 10;
    Rd = 1; Addr = 16'h0050;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    checkOutput("pre_rst_mem_rd", 16'(mem_rd), 16'd1);
    #2;
    rst = 1; Rd = 0;
    #1;
    checkOutput("rst_mid_mem_rd", 16'(mem_rd), 16'd0);
    checkOutput("rst_mid_stall", 16'(Stall), 16'd0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    applyStimulus(0, 16'h0010, 16'h0000, 1, 2);

    for (int n = 0; n < 20; n++) begin
      logic [10:0] t;
      logic [3:0]  i;
      t = 11'($urandom_range(0, 3));
      i = 4'($urandom_range(0, 15));
      applyStimulus(1'($urandom_range(0, 1)), {t, i, 1'b0}, 16'($urandom),
                    $urandom_range(1, 3), $urandom_range(1, 3));
    end

`ifdef CACHE_STATS_EN
    checkOutput("hit_count_post_rst", hit_count, 16'(exp_hits));
    checkOutput("miss_count_post_rst", miss_count, 16'(exp_misses));
`endif
    checkOutput("no_dual_strobe", 16'(both_seen), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
